softcore_buttons_pio: RTL and testbench
=======================================

Name: softcore_buttons_pio

Overview:
Avalon-MM slave input PIO. It is the read-side counterpart of the LED output port, and is used for push-buttons and switches on the softcore bus.
- Synchronises and debounces an external input vector.
- Detects edges and latches them into an edge-capture register.
- Raises a level interrupt to the Nios II when any captured edge is also enabled in the mask register.

Parameters:
WIDTH, 8, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 50000, clk cycles between debounce samples (>=1; 1 = sample every cycle)
EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero-extended above WIDTH
in_port  in  WIDTH  raw asynchronous external inputs
irq  out  1  level interrupt, active-high

Behaviour:
- Clock and reset: clk is the clock; reset_n is asynchronous, active-low. All flops reset to 0, so after reset readdata=0 and irq=0.
- Register map:
  - 0 DATA: RO, debounced value. Writes are ignored.
  - 1: reserved. Reads return 0; writes are ignored.
  - 2 IRQMASK: RW, WIDTH bits, reset 0.
  - 3 EDGECAP: read gives captured edges; write is write-1-to-clear per bit.
- Write strobe: wr = chipselect & ~write_n. Only writedata[WIDTH-1:0] is used. Read has zero wait states: readdata is a pure mux of the registers on address.
- Synchroniser: SYNC_STAGES-flop chain per bit; its output is sync.
- Debounce tick counter:
  - tcnt counts 0..DEBOUNCE_CYCLES-1 and wraps to 0.
  - tick = (tcnt == DEBOUNCE_CYCLES-1).
  - When DEBOUNCE_CYCLES = 1, tick is constantly 1.
- On tick:
  - samp <= sync.
  - For each bit i, if samp[i] == sync[i], then deb[i] <= sync[i].
  - A bit therefore changes only after two consecutive agreeing samples. A glitch shorter than one tick period is rejected.
- Edge detection:
  - deb_prev <= deb every cycle.
  - rise = deb & ~deb_prev; fall = ~deb & deb_prev.
  - edge is selected by EDGE_TYPE; for "any", edge = rise | fall.
- Edge capture: edgecap <= (edgecap & ~clr) | edge, where clr = writedata when wr && address==3, else 0.
  - A simultaneous new edge and clear on the same bit leaves the bit set (set wins).
  - Bits stay set until cleared; the register is sticky.
- Interrupt: irq = |(edgecap & irqmask), combinational from flops.
  - Writing a mask bit while the matching edgecap bit is already set raises irq the cycle after the write.
  - Clearing the mask deasserts irq the cycle after the write without clearing edgecap.
- Latency (SYNC_STAGES=2, DEBOUNCE_CYCLES=1), with in_port stable from before clock edge E1:
  - sync=1 after E2.
  - deb=1 after E4; this is when DATA reflects the new value.
  - edgecap set and irq high after E5.
  - Larger DEBOUNCE_CYCLES adds up to 2·DEBOUNCE_CYCLES cycles.
- Reset mid-operation: a pending debounce or captured edge is discarded. Inputs held high through reset produce a rising edge after release (deb goes 0→1). This behaviour is intended.
- Counter widths: tcnt uses $clog2(DEBOUNCE_CYCLES) bits, minimum 1. There is no overflow other than the defined wrap.

Decomposition:
- Package softcore_pio_pkg:
  - Address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - Constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module softcore_pio_debounce (params WIDTH, SYNC_STAGES, DEBOUNCE_CYCLES): holds the synchroniser, tick counter and samp/deb, and outputs deb.
- The top level holds the edge detect, register file, read mux and irq.

Test Plan:
- Reset and idle (in_port=8'h00, then reset release; DEBOUNCE_CYCLES=1) -> read addr0/2/3 = 0, irq=0 held.
- Latency (DEBOUNCE_CYCLES=1, in_port 8'h00→8'h05) -> addr0 reads 0x05 from cycle 4; edgecap=0x05 from cycle 5; irq stays 0 while mask=0; write mask 0x04 -> irq=1 next cycle.
- Glitch rejection (DEBOUNCE_CYCLES=16, bit3 pulsed high for 10 cycles) -> DATA, edgecap and irq stay 0. Bit3 held 40 cycles -> DATA bit3=1 and edgecap=0x08.
- W1C and collision:
  - edgecap=0x0F, write addr3 0x03 -> reads 0x0C.
  - New rising edge on bit0 in the same cycle as a write of 0x01 -> bit0 stays 1.
- EDGE_TYPE=1 (falling): in_port 0xFF→0xF0 -> edgecap=0x0F. The earlier rising edges left edgecap=0.
- Mask gating: edgecap=0x80, mask 0x80→0x00 -> irq drops the next cycle and edgecap still reads 0x80. A write to addr0/addr1 changes nothing.

Source files
------------

// File: rtl/softcore_buttons_pio_pkg.sv
// softcore_pio_pkg: register addresses and edge-type selectors for the button/switch PIO
package softcore_pio_pkg;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/softcore_buttons_pio_if.sv
// softcore_buttons_pio_if: Avalon-MM slave bus bundle
// address[1:0], chipselect, write_n, writedata[31:0] from master; readdata[31:0] from slave
interface softcore_buttons_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/softcore_buttons_pio_debounce.sv
// softcore_pio_debounce: synchronise and debounce a raw input vector
// clk, reset_n (async active-low); in_port[WIDTH] raw inputs; deb[WIDTH] debounced value
module softcore_pio_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] deb
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync, samp, agree;
    logic [CW-1:0] tcnt;
    logic tick;
    assign sync  = sync_q[SYNC_STAGES-1];
    assign tick  = (DEBOUNCE_CYCLES == 1) || (tcnt == CW'(DEBOUNCE_CYCLES - 1));
    assign agree = ~(samp ^ sync);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync_q <= '0;
            tcnt   <= '0;
            samp   <= '0;
            deb    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            tcnt   <= tick ? '0 : tcnt + 1'b1;
            if (tick) begin
                samp <= sync;
                // a bit moves only when two consecutive samples agree
                deb  <= (agree & sync) | (~agree & deb);
            end
        end
endmodule

// File: rtl/softcore_buttons_pio.sv
// softcore_buttons_pio: Avalon-MM input PIO with debounce, edge capture and level irq
// clk, reset_n (async active-low); bus (slave modport); in_port[WIDTH] raw inputs; irq level interrupt
module softcore_buttons_pio
    import softcore_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    softcore_buttons_pio_if.slave   bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);
    logic [WIDTH-1:0] deb, deb_prev, irqmask, edgecap, edges, clr, wdata;
    logic wr;
    softcore_pio_debounce #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .deb(deb)
    );
    assign wr    = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];
    assign clr   = (wr && bus.address == ADDR_EDGECAP) ? wdata : '0;
    assign edges = EDGE_TYPE == EDGE_RISE ? deb & ~deb_prev :
                   EDGE_TYPE == EDGE_FALL ? ~deb & deb_prev : deb ^ deb_prev;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            deb_prev <= '0;
            irqmask  <= '0;
            edgecap  <= '0;
        end else begin
            deb_prev <= deb;
            if (wr && bus.address == ADDR_IRQMASK) irqmask <= wdata;
            // set after clear so a same-cycle edge survives the clear
            edgecap  <= (edgecap & ~clr) | edges;
        end
    assign bus.readdata = bus.address == ADDR_DATA    ? 32'(deb) :
                          bus.address == ADDR_IRQMASK ? 32'(irqmask) :
                          bus.address == ADDR_EDGECAP ? 32'(edgecap) : 32'd0;
    assign irq = |(edgecap & irqmask);
endmodule

// File: tb/tb_softcore_buttons_pio.sv
// tb_softcore_buttons_pio: directed scoreboard bench for softcore_buttons_pio
module tb_softcore_buttons_pio;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] address = '0;
    logic chipselect = 1'b0;
    logic write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0] in0 = '0, in1 = '0, in2 = '0;
    logic irq0, irq1, irq2;
    int errors = 0;
    int checks = 0;

    typedef struct { string tag; logic [31:0] exp; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    softcore_buttons_pio_if b0 ();
    softcore_buttons_pio_if b1 ();
    softcore_buttons_pio_if b2 ();
    assign b0.address = address;  assign b0.chipselect = chipselect;
    assign b0.write_n = write_n;  assign b0.writedata = writedata;
    assign b1.address = address;  assign b1.chipselect = chipselect;
    assign b1.write_n = write_n;  assign b1.writedata = writedata;
    assign b2.address = address;  assign b2.chipselect = chipselect;
    assign b2.write_n = write_n;  assign b2.writedata = writedata;

    softcore_buttons_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) u_fast (
        .clk(clk), .reset_n(reset_n), .bus(b0), .in_port(in0), .irq(irq0));
    softcore_buttons_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)) u_slow (
        .clk(clk), .reset_n(reset_n), .bus(b1), .in_port(in1), .irq(irq1));
    softcore_buttons_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .bus(b2), .in_port(in2), .irq(irq2));

    task automatic ck(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_val(string tag, logic [31:0] e);
        sb.push_back('{tag, e});
    endtask

    task automatic check(logic [31:0] obs);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %h expected an entry", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s: got %h expected %h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic rd(int d, logic [1:0] a, string tag, logic [31:0] e);
        expect_val(tag, e);
        address = a;
        #1;
        check(d == 0 ? b0.readdata : d == 1 ? b1.readdata : b2.readdata);
    endtask

    task automatic chk_irq(int d, string tag, logic e);
        expect_val(tag, 32'(e));
        #1;
        check(32'(d == 0 ? irq0 : d == 1 ? irq1 : irq2));
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] dat);
        address = a;
        writedata = dat;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    initial begin
        ck(3);
        reset_n = 1'b1;
        rd(0, 0, "reset_data", 32'h0);
        rd(0, 2, "reset_mask", 32'h0);
        rd(0, 3, "reset_edgecap", 32'h0);
        chk_irq(0, "reset_irq", 1'b0);
        ck(5);
        rd(0, 0, "idle_data", 32'h0);
        chk_irq(0, "idle_irq", 1'b0);

        in0 = 8'h05;
        in2 = 8'hFF;
        ck(3);
        rd(0, 0, "lat_data_c3", 32'h0);
        ck(1);
        rd(0, 0, "lat_data_c4", 32'h05);
        rd(0, 3, "lat_edgecap_c4", 32'h0);
        ck(1);
        rd(0, 3, "lat_edgecap_c5", 32'h05);
        chk_irq(0, "lat_irq_mask0", 1'b0);
        ck(1);
        wr(2, 32'h04);
        chk_irq(0, "lat_irq_after_mask", 1'b1);
        rd(0, 2, "lat_mask_read", 32'h04);

        in1 = 8'h08;
        ck(10);
        in1 = 8'h00;
        ck(40);
        rd(1, 0, "glitch_data", 32'h0);
        rd(1, 3, "glitch_edgecap", 32'h0);
        chk_irq(1, "glitch_irq", 1'b0);
        in1 = 8'h08;
        ck(40);
        rd(1, 0, "held_data", 32'h08);
        rd(1, 3, "held_edgecap", 32'h08);

        in0 = 8'h0F;
        ck(6);
        rd(0, 3, "w1c_pre", 32'h0F);
        ck(1);
        wr(3, 32'h03);
        rd(0, 3, "w1c_post", 32'h0C);
        in0 = 8'h0E;
        ck(6);
        rd(0, 3, "fall_ignored", 32'h0C);
        ck(1);
        in0 = 8'h0F;
        ck(4);
        wr(3, 32'h01);
        rd(0, 3, "collision_set_wins", 32'h0D);

        ck(1);
        wr(3, 32'hFF);
        rd(0, 3, "clear_all", 32'h0);
        in0 = 8'h8F;
        ck(6);
        rd(0, 3, "mask_edgecap", 32'h80);
        ck(1);
        wr(2, 32'h80);
        chk_irq(0, "mask_irq_on", 1'b1);
        rd(0, 2, "mask_read_80", 32'h80);
        ck(1);
        wr(2, 32'h00);
        chk_irq(0, "mask_irq_off", 1'b0);
        rd(0, 3, "mask_edgecap_kept", 32'h80);
        ck(1);
        wr(0, 32'hFF);
        wr(1, 32'hFF);
        rd(0, 0, "ro_data", 32'h8F);
        rd(0, 1, "reserved_read", 32'h0);
        rd(0, 2, "ro_mask", 32'h0);
        rd(0, 3, "ro_edgecap", 32'h80);
        chk_irq(0, "ro_irq", 1'b0);

        rd(2, 3, "fall_rise_ignored", 32'h0);
        ck(1);
        in2 = 8'hF0;
        ck(6);
        rd(2, 3, "fall_edgecap", 32'h0F);
        rd(2, 0, "fall_data", 32'hF0);

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
